// File: rtl/pong_pkg.sv
// pong_pkg: shared constants for the pong game blocks.
//   - AI paddle FSM state encodings (also driven out on ai_state for debug)
//   - default screen geometry: paddle rest centre and screen midline
package pong_pkg;

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_RETURN     = 2'd1;
    localparam logic [1:0] S_WAIT_REACT = 2'd2;
    localparam logic [1:0] S_TRACK      = 2'd3;

    localparam int CENTER_Y_DEF = 240;
    localparam int HALF_X_DEF   = 320;

endpackage

// File: rtl/paddle_ai_driver.sv
// paddle_ai_driver: computer opponent for one pong paddle.
// Returns the paddle to CENTER_Y while the ball moves away, waits
// REACTION_TICKS after the ball starts approaching, then tracks ball_y.
// Emits registered up/down requests with a one-tick dead gap on reversal.
// Ports:
//   game_clk      in   game tick clock
//   reset         in   async active-low reset
//   enable        in   1 = computer drives this paddle
//   player        in   1 = left paddle, 0 = right paddle
//   ball_x/ball_y in   ball position (10 b)
//   ball_dir_x    in   1 = ball moving +x
//   paddle_y      in   paddle top y (10 b), from the paddle controller
//   height_paddle in   paddle height (8 b)
//   input_up      out  up request (registered)
//   input_down    out  down request (registered)
//   ai_state      out  current FSM state (debug)
module paddle_ai_driver
    import pong_pkg::*;
#(
    parameter int REACTION_TICKS = 8,
    parameter int DEADBAND       = 4,
    parameter int CENTER_Y       = CENTER_Y_DEF,
    parameter int HALF_X         = HALF_X_DEF
) (
    input  logic       game_clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       player,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic       ball_dir_x,
    input  logic [9:0] paddle_y,
    input  logic [7:0] height_paddle,
    output logic       input_up,
    output logic       input_down,
    output logic [1:0] ai_state
);

    localparam int CNT_W = (REACTION_TICKS < 2) ? 1 : $clog2(REACTION_TICKS + 1);
    localparam logic [CNT_W-1:0]  RT_LOAD = CNT_W'(REACTION_TICKS);
    localparam logic signed [11:0] DB     = 12'(DEADBAND);
    localparam logic signed [11:0] REST_Y = 12'(CENTER_Y);

    logic [1:0]        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              approach;
    logic [11:0]       half_h;
    logic signed [11:0] centre, target, err;
    logic              active, want_up, want_dn;

    assign approach = (player  & ~ball_dir_x & ({1'b0, ball_x} <  11'(HALF_X))) |
                      (~player &  ball_dir_x & ({1'b0, ball_x} >= 11'(HALF_X)));

    // 12-bit signed arithmetic: 1023 + 127 still fits, so nothing wraps
    assign half_h = {4'b0, height_paddle} >> 1;
    assign centre = $signed({2'b0, paddle_y}) + $signed(half_h);
    assign target = (state == S_TRACK) ? $signed({2'b0, ball_y}) : REST_Y;
    assign err    = target - centre;

    assign active  = (state == S_RETURN) || (state == S_TRACK);
    assign want_dn = err > DB;
    assign want_up = err < -DB;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   state_nxt = S_RETURN;
                S_RETURN: if (approach) begin
                    if (REACTION_TICKS == 0) begin
                        state_nxt = S_TRACK;
                    end else begin
                        state_nxt = S_WAIT_REACT;
                        cnt_nxt   = RT_LOAD;
                    end
                end
                S_WAIT_REACT: begin
                    if (!approach)     state_nxt = S_RETURN;
                    else if (cnt == '0) state_nxt = S_TRACK;
                    else               cnt_nxt   = cnt - 1'b1;
                end
                S_TRACK:  if (!approach) state_nxt = S_RETURN;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge game_clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            input_up   <= 1'b0;
            input_down <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            // a request opposite to the one currently held is suppressed for
            // one tick, which yields the dead gap before a reversal
            input_up   <= active & want_up & ~input_down;
            input_down <= active & want_dn & ~input_up;
        end
    end

    assign ai_state = state;

endmodule

// File: tb/tb_paddle_ai_driver.sv
module tb_paddle_ai_driver;

    logic       game_clk;
    logic       reset, enable, player, ball_dir_x;
    logic [9:0] ball_x, ball_y, paddle_y;
    logic [7:0] height_paddle;
    logic       up_a, down_a, up_b, down_b;
    logic [1:0] st_a, st_b;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model: [0] for REACTION_TICKS=3, [1] for REACTION_TICKS=0
    int m_st[2], m_cnt[2], m_dir[2];   // m_dir: +1 down, -1 up, 0 none

    paddle_ai_driver #(.REACTION_TICKS(3)) u_dut_a (
        .game_clk(game_clk), .reset(reset), .enable(enable), .player(player),
        .ball_x(ball_x), .ball_y(ball_y), .ball_dir_x(ball_dir_x),
        .paddle_y(paddle_y), .height_paddle(height_paddle),
        .input_up(up_a), .input_down(down_a), .ai_state(st_a));

    paddle_ai_driver #(.REACTION_TICKS(0)) u_dut_b (
        .game_clk(game_clk), .reset(reset), .enable(enable), .player(player),
        .ball_x(ball_x), .ball_y(ball_y), .ball_dir_x(ball_dir_x),
        .paddle_y(paddle_y), .height_paddle(height_paddle),
        .input_up(up_b), .input_down(down_b), .ai_state(st_b));

    initial game_clk = 1'b0;
    always #5 game_clk = ~game_clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic void model_next(input int rt, input int s, input int c, input int d,
                                       output int ns, output int nc, output int nd);
        bit ap;
        int err, want;
        ap = (player && !ball_dir_x && int'(ball_x) < 320) ||
             (!player && ball_dir_x && int'(ball_x) >= 320);
        nd = 0;
        if (s == 1 || s == 3) begin
            err  = ((s == 3) ? int'(ball_y) : 240) - (int'(paddle_y) + int'(height_paddle) / 2);
            want = (err > 4) ? 1 : ((err < -4) ? -1 : 0);
            nd   = (want != 0 && d != 0 && want != d) ? 0 : want;
        end
        ns = s;
        nc = c;
        if (!enable) ns = 0;
        else begin
            case (s)
                0: ns = 1;
                1: if (ap) begin
                       if (rt == 0) ns = 3;
                       else begin ns = 2; nc = rt; end
                   end
                2: if (!ap) ns = 1;
                   else if (c == 0) ns = 3;
                   else nc = c - 1;
                default: if (!ap) ns = 1;
            endcase
        end
    endfunction

    always @(posedge game_clk or negedge reset) begin : model
        int ns0, nc0, nd0, ns1, nc1, nd1;
        if (!reset) begin
            m_st  <= '{0, 0};
            m_cnt <= '{0, 0};
            m_dir <= '{0, 0};
        end else begin
            model_next(3, m_st[0], m_cnt[0], m_dir[0], ns0, nc0, nd0);
            model_next(0, m_st[1], m_cnt[1], m_dir[1], ns1, nc1, nd1);
            m_st  <= '{ns0, ns1};
            m_cnt <= '{nc0, nc1};
            m_dir <= '{nd0, nd1};
        end
    end

    // one clock edge, then compare both DUTs against the model
    task automatic tick();
        @(posedge game_clk);
        @(negedge game_clk);
        chk("a_state", int'(st_a),   m_st[0]);
        chk("a_up",    int'(up_a),   int'(m_dir[0] == -1));
        chk("a_down",  int'(down_a), int'(m_dir[0] == 1));
        chk("b_state", int'(st_b),   m_st[1]);
        chk("b_up",    int'(up_b),   int'(m_dir[1] == -1));
        chk("b_down",  int'(down_b), int'(m_dir[1] == 1));
    endtask

    task automatic chk_a(input string tag, input int st, input int up, input int dn);
        chk({tag, "_state"}, int'(st_a),   st);
        chk({tag, "_up"},    int'(up_a),   up);
        chk({tag, "_down"},  int'(down_a), dn);
    endtask

    initial begin
        int guard;
        reset = 1'b0; enable = 1'b1; player = 1'b1; ball_dir_x = 1'b1;
        ball_x = 10'd100; ball_y = 10'd240; paddle_y = 10'd200; height_paddle = 8'd64;

        // reset held with enable high
        #1 chk_a("rst_hold", 0, 0, 0);
        repeat (2) @(negedge game_clk);
        chk_a("rst_hold_clk", 0, 0, 0);
        reset = 1'b1;
        #1 chk_a("rst_rel", 0, 0, 0);

        // IDLE -> RETURN, then down toward centre 240 from centre 232
        tick(); chk_a("to_return", 1, 0, 0);
        tick(); chk_a("ret_down", 1, 0, 1);
        paddle_y = 10'd208;
        tick(); chk_a("ret_rest", 1, 0, 0);

        // approach with reaction delay 3
        ball_dir_x = 1'b0; ball_y = 10'd100;
        tick(); chk_a("wr_enter", 2, 0, 0);
        paddle_y = 10'd200;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_a("wr_hold", 2, 0, 0);
        end
        tick(); chk_a("trk_enter", 3, 0, 0);
        tick(); chk_a("trk_up", 3, 1, 0);

        // reversal gap
        ball_y = 10'd400;
        tick(); chk_a("rev_gap", 3, 0, 0);
        tick(); chk_a("rev_down", 3, 0, 1);

        // approach lost mid-wait, then full wait again
        ball_dir_x = 1'b1;
        tick(); chk("leave_state", int'(st_a), 1);
        ball_dir_x = 1'b0;
        tick(); chk("wr2_state", int'(st_a), 2);
        tick(); chk("wr2_state2", int'(st_a), 2);
        ball_dir_x = 1'b1;
        tick(); chk("wr_abort", int'(st_a), 1);
        ball_dir_x = 1'b0;
        tick(); chk("wr3_enter", int'(st_a), 2);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("wr_full", int'(st_a), 2);
        end
        tick(); chk("wr_done", int'(st_a), 3);

        // enable drop in TRACK
        tick();
        enable = 1'b0;
        tick(); chk("en_off", int'(st_a), 0);
        tick(); chk_a("en_off_out", 0, 0, 0);
        enable = 1'b1;

        // back into TRACK with down held, then async reset
        guard = 0;
        while (!(st_a == 2'd3 && down_a == 1'b1) && guard < 20) begin
            tick();
            guard++;
        end
        chk("trk_reach", int'(guard < 20), 1);
        #2 reset = 1'b0;
        #1 chk_a("rst_async", 0, 0, 0);
        chk("rst_async_b", int'(up_b) + int'(down_b) + int'(st_b), 0);
        @(negedge game_clk);
        reset = 1'b1;

        // randomized phase
        for (int n = 0; n < 800; n++) begin
            enable = ($urandom % 16) != 0;
            if ($urandom % 40 == 0) player = ~player;
            if ($urandom % 10 == 0) ball_dir_x = ~ball_dir_x;
            if ($urandom % 8 == 0)  ball_x = 10'($urandom % 640);
            ball_y = 10'($urandom % 480);
            if ($urandom % 4 == 0) paddle_y = 10'($urandom_range(100, 400));
            if ($urandom % 16 == 0) height_paddle = 8'($urandom_range(16, 255));
            if ($urandom % 64 == 0) begin
                #2 reset = 1'b0;
                #1 chk_a("rnd_rst", 0, 0, 0);
                #1 reset = 1'b1;
            end
            tick();
            chk("a_excl", int'(up_a & down_a), 0);
            chk("b_excl", int'(up_b & down_b), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/paddle_ai_driver.md
PADDLE_AI_DRIVER -- requirements
Module: paddle_ai_driver

Interface
REQ-001 SHALL have parameter REACTION_TICKS, default 8, meaning the game_clk ticks between approach detection and tracking start.
REQ-002 SHALL have parameter DEADBAND, default 4, meaning the pixel tolerance around the target where no movement is requested.
REQ-003 SHALL have parameter CENTER_Y, default 240, meaning the rest position for the paddle centre.
REQ-004 SHALL have parameter HALF_X, default 320, meaning the screen midline x coordinate.
REQ-005 SHALL have port game_clk, input, 1 bit: the single clock, one game tick per edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port enable, input, 1 bit: 1 = the computer drives this paddle.
REQ-008 SHALL have port player, input, 1 bit: 1 = left paddle, 0 = right paddle.
REQ-009 SHALL have port ball_x, input, 10 bits: ball x position.
REQ-010 SHALL have port ball_y, input, 10 bits: ball y position.
REQ-011 SHALL have port ball_dir_x, input, 1 bit: 1 = ball moving +x (right).
REQ-012 SHALL have port paddle_y, input, 10 bits: paddle top y, fed back from the paddle controller.
REQ-013 SHALL have port height_paddle, input, 8 bits: paddle height.
REQ-014 SHALL have port input_up, output, 1 bit: up request to the paddle controller.
REQ-015 SHALL have port input_down, output, 1 bit: down request to the paddle controller.
REQ-016 SHALL have port ai_state, output, 2 bits: current FSM state, for debug.

Function
REQ-017 SHALL compute paddle centre = paddle_y + height_paddle/2, and all error arithmetic, at 12-bit signed width with no wrap.
REQ-018 SHALL define approach = (player & !ball_dir_x & ball_x < HALF_X) | (!player & ball_dir_x & ball_x >= HALF_X).
REQ-019 SHALL implement states IDLE=0, RETURN=1, WAIT_REACT=2, TRACK=3.
REQ-020 SHALL go to IDLE on the next edge from any state whenever enable = 0.
REQ-021 SHALL go from IDLE to RETURN when enable = 1.
REQ-022 SHALL go from RETURN to WAIT_REACT on approach, loading the counter with REACTION_TICKS.
REQ-023 SHALL, in WAIT_REACT, decrement the counter each tick, go to TRACK when the counter = 0, and go to RETURN if approach drops (the counter is reloaded on re-entry).
REQ-024 SHALL go from RETURN directly to TRACK on approach when REACTION_TICKS = 0.
REQ-025 SHALL go from TRACK to RETURN when approach = 0.
REQ-026 SHALL use target = ball_y in TRACK and target = CENTER_Y in RETURN; error = target - centre.
REQ-027 SHALL request down when error > DEADBAND, up when error < -DEADBAND, and neither otherwise (|error| <= DEADBAND).
REQ-028 SHALL force input_up and input_down to 0 in IDLE and WAIT_REACT.
REQ-029 SHALL register both outputs, with one tick of latency from state/inputs to outputs.
REQ-030 SHALL never assert input_up and input_down together.
REQ-031 SHALL, on a reversal request (up to down or down to up), drive one tick with both outputs at 0 before asserting the new direction.

Reset
REQ-032 SHALL, while reset = 0, asynchronously force state = IDLE, counter = 0, input_up = 0, input_down = 0 and ai_state = 0.
REQ-033 SHALL, on release of reset, start evaluating on the first game_clk edge; a reset mid-TRACK clears the outputs immediately, without waiting for a clock edge.

Structure
REQ-034 SHALL place the state encodings, CENTER_Y and HALF_X defaults in shared package pong_pkg.
REQ-035 SHALL keep the FSM and reversal guard in a single module with no sub-modules.

Verification (height_paddle = 64, DEADBAND = 4)
REQ-036 SHALL verify that holding reset = 0 with enable = 1 keeps the outputs at 0 and ai_state = 0, both at once and after release until the first edge.
REQ-037 SHALL verify that enable = 1, ball moving away and paddle_y = 200 (centre 232) give input_down = 1 the tick after RETURN; with paddle_y = 208, both outputs are 0.
REQ-038 SHALL verify that, with REACTION_TICKS = 3, approach rising at edge N gives outputs 0 through WAIT_REACT, TRACK at edge N+4, and ball_y = 100 with paddle_y = 200 gives input_up = 1 at edge N+5.
REQ-039 SHALL verify that, in TRACK with input_up = 1, a ball_y jump to 400 gives one tick with both outputs 0 and then input_down = 1.
REQ-040 SHALL verify that ball_dir_x flipping mid-WAIT_REACT gives RETURN next edge, and that the next approach waits the full REACTION_TICKS again.
REQ-041 SHALL verify that enable dropping in TRACK gives IDLE with both outputs 0 one tick later, and that asserting reset = 0 mid-TRACK clears the outputs with no clock edge.
